sb_arb: RTL and testbench
=========================

Name: sb_arb

Overview:
- Parametrised successor to the two-master system bus switch.
- Arbitrates NUM_M masters onto one memory slave port, with fixed-priority or round-robin selection.
- Uses an explicit request/grant/read-valid handshake and supports a slave read latency of RD_LAT cycles.
- Keeps the codebase's big-endian byte-lane swap, write lane enables and load sign/zero extension. Sits between the core/debug masters and the data RAM.

Parameters:
NUM_M, 4, number of masters (2..8)
AW, 32, address width
RD_LAT, 1, cycles from read issue to valid s_rdata (1..7)
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round robin

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
m_req  in  NUM_M  per-master request, held until granted
m_we  in  NUM_M  1 = write, 0 = read
m_un_sign  in  NUM_M  1 = sign-extend loads, 0 = zero-extend
m_byte_mask  in  4*NUM_M  master i uses bits [4i+3:4i]; bit3 = word, bit1 = half, bit0 = byte
m_addr  in  AW*NUM_M  master i uses bits [AW*i+AW-1:AW*i]
m_wdata  in  32*NUM_M  master i uses bits [32i+31:32i]
m_gnt  out  NUM_M  one-hot grant pulse, same cycle as slave issue
m_rvalid  out  NUM_M  one-hot read-data-valid pulse
m_rdata  out  32  formatted read data, shared; valid only with m_rvalid
s_rdata  in  32  slave read data
s_re_o  out  1  read strobe, issue cycle only
s_rw_o  out  4  write lane enables, 0 = no write
s_addr_o  out  AW  slave address
s_wdata_o  out  32  lane-formatted write data

Behaviour:
- State is IDLE or RD_WAIT. Registers: state, owner (index), cnt (3 bits), rr_ptr, rd_mask, rd_sign.
- Reset (rst = 1 at an edge): state = IDLE, owner = 0, cnt = 0, rr_ptr = 0.
- While in reset and whenever idle with no request, all outputs are 0: m_gnt, m_rvalid, m_rdata, s_re_o, s_rw_o, s_addr_o, s_wdata_o.
- Arbitration happens in IDLE only and is combinational on m_req.
  - ARB_MODE = 0: the lowest index among requesters wins.
  - ARB_MODE = 1: search starts at rr_ptr and wraps modulo NUM_M. After any grant to w, rr_ptr <= (w+1) mod NUM_M.
- Write grant, IDLE, winner w with m_we = 1, same cycle:
  - m_gnt[w] = 1, s_addr_o = addr_w.
  - s_rw_o = {mask[0], mask[1], mask[2], mask[3]}.
  - s_wdata_o: word = {wd[7:0], wd[15:8], wd[23:16], wd[31:24]}; half = {wd[7:0], wd[15:8], 16'b0}; byte = {wd[7:0], 24'b0}. Mask precedence is bit3 > bit1 > bit0.
  - State stays IDLE; back-to-back writes from any masters are allowed every cycle.
- Read grant, IDLE, winner w with m_we = 0, same cycle:
  - m_gnt[w] = 1, s_re_o = 1, s_addr_o = addr_w, s_rw_o = 0.
  - Latch owner = w, rd_mask, rd_sign, and the address. cnt <= 1, state <= RD_WAIT.
- RD_WAIT:
  - s_addr_o holds the latched address; s_re_o = 0; no grants are issued; requests stay pending.
  - cnt increments each cycle.
  - In the cycle where cnt == RD_LAT: m_rvalid[owner] = 1 and m_rdata = formatted s_rdata, then state <= IDLE. New arbitration begins the following cycle.
- Read formatting (sx = rd_sign & sign bit):
  - word = byte-reversed s_rdata.
  - half = {16{sx of s_rdata[23]}, s_rdata[23:16], s_rdata[31:24]}.
  - byte = {24{sx of s_rdata[31]}, s_rdata[31:24]}.
- Mask of 0 (no valid size bit):
  - Grant is still given.
  - A write drives s_rw_o = 0.
  - A read completes normally with m_rdata = 0.
- A master may change its request fields the cycle after m_gnt. A request dropped before grant is simply not served.
- rst asserted during RD_WAIT: return to IDLE, no m_rvalid is ever produced for that read, rr_ptr = 0.
- A read issue cycle is RD_LAT+1 cycles of bus occupancy. A write is 1 cycle.

Test Plan:
- Fixed mode, m_req = 4'b0110, both writes: m_gnt = 0010 in cycle 0, then 0100 in cycle 1 after master1 drops its request. Master1 word write of 0x11223344: s_wdata_o = 0x44332211, s_rw_o = 4'b1111.
- Round robin, all 4 masters issuing continuous writes: grant sequence 0, 1, 2, 3, 0; rr_ptr wraps from 3 to 0.
- RD_LAT = 2, master2 halfword read, m_un_sign = 1, s_rdata = 0x80FF0000: m_gnt[2] and s_re_o at T; m_rvalid[2] at T+2 with m_rdata = 0xFFFFFF80. No grant occurs at T+1 or T+2 despite a pending m_req[0].
- Byte read of s_rdata = 0x9A000000: m_un_sign = 0 gives m_rdata = 0x0000009A; m_un_sign = 1 gives 0xFFFFFF9A. Byte write of 0xAB gives s_wdata_o = 0xAB000000, s_rw_o = 4'b1000.
- rst pulsed at T+1 of an RD_LAT = 3 read: no m_rvalid pulse occurs; all outputs are 0 in the reset cycle; the next request is granted normally.
- m_byte_mask = 0 write: m_gnt pulses with s_rw_o = 0. Mask = 0 read: m_rvalid pulses with m_rdata = 0.

Source files
------------

// File: rtl/sb_arb.sv
// Multi-master system bus arbiter onto a single memory slave port.
// Big-endian lane swap on writes, lane select plus sign/zero extension on reads.
module sb_arb #(
  parameter int NUM_M    = 4,
  parameter int AW       = 32,
  parameter int RD_LAT   = 1,
  parameter int ARB_MODE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_M-1:0]      m_req,
  input  logic [NUM_M-1:0]      m_we,
  input  logic [NUM_M-1:0]      m_un_sign,
  input  logic [4*NUM_M-1:0]    m_byte_mask,
  input  logic [AW*NUM_M-1:0]   m_addr,
  input  logic [32*NUM_M-1:0]   m_wdata,
  output logic [NUM_M-1:0]      m_gnt,
  output logic [NUM_M-1:0]      m_rvalid,
  output logic [31:0]           m_rdata,
  input  logic [31:0]           s_rdata,
  output logic                  s_re_o,
  output logic [3:0]            s_rw_o,
  output logic [AW-1:0]         s_addr_o,
  output logic [31:0]           s_wdata_o
);
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t        r_state;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_rr_ptr;
  logic [2:0]    r_cnt;
  logic [3:0]    r_rd_mask;
  logic          r_rd_sign;
  logic [AW-1:0] r_addr;

  logic          w_any;
  logic [IW-1:0] w_win;
  logic [IW-1:0] w_idx;
  logic          w_fire;
  logic          w_done;
  logic          w_we;
  logic [3:0]    w_mask;
  logic [AW-1:0] w_addr;
  logic [31:0]   w_wd;

  function automatic logic [31:0] fmt_wr(input logic [3:0] mk, input logic [31:0] wd);
    if (mk[3])      return {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    else if (mk[1]) return {wd[7:0], wd[15:8], 16'b0};
    else if (mk[0]) return {wd[7:0], 24'b0};
    else            return '0;
  endfunction

  function automatic logic [31:0] fmt_rd(input logic [3:0] mk, input logic sg, input logic [31:0] rd);
    if (mk[3])      return {rd[7:0], rd[15:8], rd[23:16], rd[31:24]};
    else if (mk[1]) return {{16{sg & rd[23]}}, rd[23:16], rd[31:24]};
    else if (mk[0]) return {{24{sg & rd[31]}}, rd[31:24]};
    else            return '0;
  endfunction

  // Round robin starts the search at r_rr_ptr; fixed priority starts at 0.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (ARB_MODE == 1) w_idx = IW'((int'(r_rr_ptr) + i) % NUM_M);
      else               w_idx = IW'(i);
      if (!w_any && m_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_we   = m_we[w_win];
  assign w_mask = m_byte_mask[4*int'(w_win) +: 4];
  assign w_addr = m_addr[AW*int'(w_win) +: AW];
  assign w_wd   = m_wdata[32*int'(w_win) +: 32];
  assign w_fire = !rst && (r_state == IDLE) && w_any;
  assign w_done = !rst && (r_state == RD_WAIT) && (r_cnt == 3'(RD_LAT));

  always_comb begin
    m_gnt     = '0;
    m_rvalid  = '0;
    m_rdata   = '0;
    s_re_o    = 1'b0;
    s_rw_o    = '0;
    s_addr_o  = '0;
    s_wdata_o = '0;
    if (w_fire) begin
      m_gnt[w_win] = 1'b1;
      s_addr_o     = w_addr;
      if (w_we) begin
        s_rw_o    = {w_mask[0], w_mask[1], w_mask[2], w_mask[3]};
        s_wdata_o = fmt_wr(w_mask, w_wd);
      end else begin
        s_re_o = 1'b1;
      end
    end
    if (!rst && r_state == RD_WAIT) s_addr_o = r_addr;
    if (w_done) begin
      m_rvalid[r_owner] = 1'b1;
      m_rdata           = fmt_rd(r_rd_mask, r_rd_sign, s_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_rr_ptr  <= '0;
      r_rd_mask <= '0;
      r_rd_sign <= 1'b0;
      r_addr    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_any) begin
          r_rr_ptr <= (int'(w_win) == NUM_M-1) ? '0 : w_win + IW'(1);
          if (!w_we) begin
            r_owner   <= w_win;
            r_rd_mask <= w_mask;
            r_rd_sign <= m_un_sign[w_win];
            r_addr    <= w_addr;
            r_cnt     <= 3'd1;
            r_state   <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          // Bus stays owned by the read until the data-valid cycle.
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'(RD_LAT)) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sb_arb.sv
// Directed bench: a fixed-priority RD_LAT=2 arbiter and a round-robin RD_LAT=3
// arbiter driven by the same masters; read data checked through a scoreboard.
module tb_sb_arb;
  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req, we, us;
  logic [15:0]   mask;
  logic [127:0]  addr, wd;
  logic [31:0]   srd;

  logic [3:0]  gnt_a, rv_a, rw_a, gnt_b, rv_b, rw_b;
  logic [31:0] rd_a, addr_a, wd_a, rd_b, addr_b, wd_b;
  logic        re_a, re_b;

  int checks   = 0;
  int failures = 0;

  typedef struct packed { logic [3:0] v; logic [31:0] d; } rexp_t;
  rexp_t qa[$];
  rexp_t qb[$];
  rexp_t ea, eb;

  always #5 clk = ~clk;

  sb_arb #(.NUM_M(4), .AW(32), .RD_LAT(2), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_un_sign(us),
    .m_byte_mask(mask), .m_addr(addr), .m_wdata(wd),
    .m_gnt(gnt_a), .m_rvalid(rv_a), .m_rdata(rd_a), .s_rdata(srd),
    .s_re_o(re_a), .s_rw_o(rw_a), .s_addr_o(addr_a), .s_wdata_o(wd_a));

  sb_arb #(.NUM_M(4), .AW(32), .RD_LAT(3), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(rst), .m_req(req), .m_we(we), .m_un_sign(us),
    .m_byte_mask(mask), .m_addr(addr), .m_wdata(wd),
    .m_gnt(gnt_b), .m_rvalid(rv_b), .m_rdata(rd_b), .s_rdata(srd),
    .s_re_o(re_b), .s_rw_o(rw_b), .s_addr_o(addr_b), .s_wdata_o(wd_b));

  wire logic any_out = |{gnt_a, rv_a, rd_a, re_a, rw_a, addr_a, wd_a,
                         gnt_b, rv_b, rd_b, re_b, rw_b, addr_b, wd_b};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic setm(input int i, input logic w, input logic s, input logic [3:0] mk,
                      input logic [31:0] a, input logic [31:0] d);
    we[i] = w;
    us[i] = s;
    mask[4*i +: 4] = mk;
    addr[32*i +: 32] = a;
    wd[32*i +: 32] = d;
  endtask

  task automatic push2(input logic [3:0] v, input logic [31:0] d);
    qa.push_back('{v, d});
    qb.push_back('{v, d});
  endtask

  // Scoreboard: every read-valid pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rv_a !== 4'b0) begin
      if (qa.size() == 0) chk("fix_unexpected_rvalid", {28'b0, rv_a}, 64'h0);
      else begin
        ea = qa.pop_front();
        chk("fix_rvalid_rdata", {rv_a, rd_a}, {ea.v, ea.d});
      end
    end
    if (rv_b !== 4'b0) begin
      if (qb.size() == 0) chk("rr_unexpected_rvalid", {28'b0, rv_b}, 64'h0);
      else begin
        eb = qb.pop_front();
        chk("rr_rvalid_rdata", {rv_b, rd_b}, {eb.v, eb.d});
      end
    end
  end

  initial begin
    rst = 1'b1; req = '0; we = '0; us = '0; mask = '0; addr = '0; wd = '0; srd = '0;
    setm(0, 1'b1, 1'b0, 4'hF, 32'h10, 32'hAABBCCDD);
    req = 4'b0001;
    cyc(); smp();
    chk("reset_outputs_zero", {63'b0, any_out}, 64'h0);
    cyc(); rst = 1'b0; req = '0;
    smp();
    chk("idle_outputs_zero", {63'b0, any_out}, 64'h0);

    // Fixed priority, two writers
    cyc();
    setm(1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h11223344);
    setm(2, 1'b1, 1'b0, 4'h1, 32'h200, 32'h000000AB);
    req = 4'b0110;
    smp();
    chk("fix_gnt_c0", gnt_a, 4'b0010);
    chk("fix_word_wdata", wd_a, 32'h44332211);
    chk("fix_word_rw", rw_a, 4'b1111);
    chk("fix_word_addr", addr_a, 32'h100);
    chk("rr_gnt_c0", gnt_b, 4'b0010);
    cyc(); req = 4'b0100;
    smp();
    chk("fix_gnt_c1", gnt_a, 4'b0100);
    chk("fix_byte_wdata", wd_a, 32'hAB000000);
    chk("fix_byte_rw", rw_a, 4'b1000);
    chk("rr_gnt_c1", gnt_b, 4'b0100);

    // Reset clears rr_ptr, then round robin over four continuous writers
    cyc(); req = '0; rst = 1'b1;
    cyc(); rst = 1'b0;
    for (int i = 0; i < 4; i++) setm(i, 1'b1, 1'b0, 4'hF, 32'h20 + 32'(i), 32'(i));
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      smp();
      chk("rr_seq_gnt", gnt_b, 64'(4'b0001 << (k % 4)));
      chk("fix_seq_gnt", gnt_a, 4'b0001);
      cyc();
    end
    req = '0;

    // Halfword signed read from master2, master0 queues a write behind it
    cyc();
    setm(2, 1'b0, 1'b1, 4'b0011, 32'h300, 32'h0);
    srd = 32'h80FF0000;
    req = 4'b0100;
    push2(4'b0100, 32'hFFFFFF80);
    smp();
    chk("rd_fix_gnt", gnt_a, 4'b0100);
    chk("rd_fix_re", re_a, 1'b1);
    chk("rd_fix_addr", addr_a, 32'h300);
    chk("rd_fix_rw", rw_a, 4'b0000);
    chk("rd_rr_gnt", gnt_b, 4'b0100);
    chk("rd_rr_re", re_b, 1'b1);
    cyc();
    setm(0, 1'b1, 1'b0, 4'hF, 32'h40, 32'h01020304);
    req = 4'b0001;
    smp();
    chk("rd_t1_gnt", {gnt_a, gnt_b}, 8'h00);
    chk("rd_t1_re", re_a, 1'b0);
    chk("rd_t1_addr_held", addr_a, 32'h300);
    chk("rd_t1_rvalid", {rv_a, rv_b}, 8'h00);
    cyc(); smp();
    chk("rd_t2_gnt", {gnt_a, gnt_b}, 8'h00);
    chk("rd_t2_rvalid", {rv_a, rv_b}, 8'h40);
    cyc(); smp();
    chk("rd_t3_gnt", {gnt_a, gnt_b}, 8'h10);
    chk("rd_t3_rvalid", {rv_a, rv_b}, 8'h04);
    cyc(); smp();
    chk("rd_t4_rr_gnt", gnt_b, 4'b0001);
    cyc(); req = '0;

    // Byte reads: zero then sign extension
    cyc();
    setm(1, 1'b0, 1'b0, 4'b0001, 32'h500, 32'h0);
    srd = 32'h9A000000;
    req = 4'b0010;
    push2(4'b0010, 32'h0000009A);
    smp();
    chk("byte_rd_gnt", {gnt_a, gnt_b}, 8'h22);
    cyc(); req = '0;
    repeat (4) cyc();
    setm(1, 1'b0, 1'b1, 4'b0001, 32'h504, 32'h0);
    req = 4'b0010;
    push2(4'b0010, 32'hFFFFFF9A);
    smp();
    chk("sbyte_rd_gnt", {gnt_a, gnt_b}, 8'h22);
    cyc(); req = '0;
    repeat (4) cyc();

    // Mask 0 write and read
    setm(3, 1'b1, 1'b0, 4'h0, 32'h600, 32'hDEADBEEF);
    req = 4'b1000;
    smp();
    chk("mask0_wr_gnt", {gnt_a, gnt_b}, 8'h88);
    chk("mask0_wr_rw", {rw_a, rw_b}, 8'h00);
    cyc();
    setm(3, 1'b0, 1'b1, 4'h0, 32'h700, 32'h0);
    srd = 32'hFFFFFFFF;
    push2(4'b1000, 32'h0);
    smp();
    chk("mask0_rd_gnt", {gnt_a, gnt_b}, 8'h88);
    cyc(); req = '0;
    repeat (4) cyc();

    // Reset one cycle into a read: the read must vanish
    setm(0, 1'b0, 1'b0, 4'hF, 32'h800, 32'h0);
    req = 4'b0001;
    smp();
    chk("abort_rd_gnt", {gnt_b, 3'b0, re_b}, 8'h11);
    cyc(); req = '0; rst = 1'b1;
    smp();
    chk("abort_rst_outputs_zero", {63'b0, any_out}, 64'h0);
    cyc(); rst = 1'b0;
    repeat (4) cyc();
    setm(1, 1'b1, 1'b0, 4'hF, 32'h900, 32'h55667788);
    req = 4'b0010;
    smp();
    chk("post_abort_gnt", {gnt_a, gnt_b}, 8'h22);
    chk("post_abort_wdata", wd_b, 32'h88776655);
    cyc(); req = '0;
    repeat (3) cyc();

    chk("fix_queue_drained", 64'(qa.size()), 64'h0);
    chk("rr_queue_drained", 64'(qb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
